// File: rtl/counter_pkg.sv
// ============================================================================
// Package : counter_pkg
// Shared direction encodings and step function for the counter family.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Returns {wrap, next}; operands are 33 bits so any WIDTH up to 32 plus
    // the 2**WIDTH modulus fit without overflow.
    function automatic logic [33:0] next_count(
        input logic [32:0] value,
        input logic        up_dn,
        input logic [32:0] modulo
    );
        logic        wrap;
        logic [32:0] nxt;
        if (up_dn == DIR_UP) begin
            wrap = (value == modulo - 33'd1);
            nxt  = wrap ? 33'd0 : value + 33'd1;
        end else begin
            wrap = (value == 33'd0);
            nxt  = wrap ? modulo - 33'd1 : value - 33'd1;
        end
        return {wrap, nxt};
    endfunction

endpackage

`default_nettype wire

// File: rtl/updown_counter.sv
// ============================================================================
// Module  : updown_counter
// WIDTH-bit modulo-MODULO up/down counter with load, enable and a registered
// one-cycle wrap flag. Define UPDOWN_COUNTER_STICKY_OVF_EN for ovf_sticky/ovf_clr.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH  = 8,
    parameter logic [32:0]       MODULO = 33'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             count_en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             flag
`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
    ,
    output logic             ovf_sticky,
    input  logic             ovf_clr
`endif
);

    localparam logic [32:0]      MOD_M1  = MODULO - 33'd1;
    localparam logic [WIDTH-1:0] MAX_VAL = MOD_M1[WIDTH-1:0];

    if (MODULO < 33'd2 || MODULO > (33'd1 << WIDTH)) begin : g_param_check
        $fatal(1, "updown_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end

    logic [WIDTH-1:0] value_q, value_d;
    logic             flag_q,  flag_d;
    logic [33:0]      w_step;
    logic [32:0]      w_load_ext;
    logic [WIDTH-1:0] w_load_clamped;
    logic [32:WIDTH]  w_unused_step_hi;

    assign w_step           = next_count(33'(value_q), up_dn, MODULO);
    assign w_unused_step_hi = w_step[32:WIDTH];
    assign w_load_ext       = 33'(load_val);
    assign w_load_clamped   = (w_load_ext < MODULO) ? load_val : MAX_VAL;

    always_comb begin
        value_d = value_q;
        flag_d  = 1'b0;
        if (load) begin
            value_d = w_load_clamped;
        end else if (count_en) begin
            value_d = w_step[WIDTH-1:0];
            flag_d  = w_step[33];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            flag_q  <= flag_d;
        end
    end

    assign value = value_q;
    assign flag  = flag_q;

`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
    logic ovf_sticky_q;

    // A wrap on the same edge as a clear keeps the indicator set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_sticky_q <= 1'b0;
        end else if (flag_d) begin
            ovf_sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_updown_counter.sv
// ============================================================================
// Module  : tb_updown_counter
// Scoreboarded bench: three counters (MODULO 10, 256, 2) against a modular-arithmetic model.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_updown_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n  = 1'b0;
    logic       count_en = 1'b0;
    logic       up_dn    = 1'b1;
    logic       load     = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       ovf_clr  = 1'b0;

    logic [7:0] v0, v1, v2;
    logic       f0, f1, f2;
    logic       s0, s1, s2;

    int n_pass  = 0;
    int n_total = 0;

    updown_counter #(.WIDTH(8), .MODULO(33'd10)) u_m10 (
        .clk(clk), .reset_n(reset_n), .count_en(count_en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .value(v0), .flag(f0)
`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
        , .ovf_sticky(s0), .ovf_clr(ovf_clr)
`endif
    );

    updown_counter #(.WIDTH(8), .MODULO(33'd256)) u_m256 (
        .clk(clk), .reset_n(reset_n), .count_en(count_en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .value(v1), .flag(f1)
`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
        , .ovf_sticky(s1), .ovf_clr(ovf_clr)
`endif
    );

    updown_counter #(.WIDTH(8), .MODULO(33'd2)) u_m2 (
        .clk(clk), .reset_n(reset_n), .count_en(count_en), .up_dn(up_dn),
        .load(load), .load_val(load_val), .value(v2), .flag(f2)
`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
        , .ovf_sticky(s2), .ovf_clr(ovf_clr)
`endif
    );

`ifndef UPDOWN_COUNTER_STICKY_OVF_EN
    assign s0 = 1'b0;
    assign s1 = 1'b0;
    assign s2 = 1'b0;
`endif

    function automatic int mod_of(input int i);
        case (i)
            0:       return 10;
            1:       return 256;
            default: return 2;
        endcase
    endfunction

    function automatic logic [9:0] act_of(input int i);
        case (i)
            0:       return {s0, f0, v0};
            1:       return {s1, f1, v1};
            default: return {s2, f2, v2};
        endcase
    endfunction

    // Reference model: plain modular arithmetic on integers.
    int         m_val [3] = '{0, 0, 0};
    logic       m_stk [3] = '{1'b0, 1'b0, 1'b0};
    logic [9:0] exp_q [3][$];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int   m;
            logic mf;
            m  = mod_of(i);
            mf = 1'b0;
            if (!reset_n) begin
                m_val[i] = 0;
                m_stk[i] = 1'b0;
            end else begin
                if (load) begin
                    m_val[i] = (int'(load_val) < m) ? int'(load_val) : m - 1;
                end else if (count_en && up_dn) begin
                    mf       = (m_val[i] + 1 == m);
                    m_val[i] = (m_val[i] + 1) % m;
                end else if (count_en) begin
                    mf       = (m_val[i] == 0);
                    m_val[i] = (m_val[i] + m - 1) % m;
                end
                if (mf)           m_stk[i] = 1'b1;
                else if (ovf_clr) m_stk[i] = 1'b0;
            end
            exp_q[i].push_back({m_stk[i], mf, 8'(m_val[i])});
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            logic [9:0] e, a;
            a = act_of(i);
            n_total++;
            if (exp_q[i].size() == 0) begin
                $display("FAIL sb_empty[%0d]: got value=%0d with no expectation queued", i, a[7:0]);
            end else begin
                e = exp_q[i].pop_front();
`ifndef UPDOWN_COUNTER_STICKY_OVF_EN
                e[9] = 1'b0;
`endif
                if (a === e) n_pass++;
                else $display("FAIL sb[%0d] t=%0t: got sticky=%0b flag=%0b value=%0d, expected sticky=%0b flag=%0b value=%0d",
                              i, $time, a[9], a[8], a[7:0], e[9], e[8], e[7:0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input logic rn, input logic ld, input logic [7:0] lv,
                       input logic ce, input logic ud, input logic clr);
        @(negedge clk);
        reset_n  = rn;
        load     = ld;
        load_val = lv;
        count_en = ce;
        up_dn    = ud;
        ovf_clr  = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset, count a bit, then reset mid-count
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("pre_reset_m256", int'(v1), 5);
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("reset_value_m256", int'(v1), 0);
        chk("reset_flag_m256", int'(f1), 0);
        chk("reset_value_m10", int'(v0), 0);

        // Up wrap through MODULO=10
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
            if (k == 9) begin
                chk("up9_value", int'(v0), 9);
                chk("up9_flag", int'(f0), 0);
            end
        end
        chk("upwrap_value", int'(v0), 0);
        chk("upwrap_flag", int'(f0), 1);
        chk("upwrap_m256_value", int'(v1), 10);
        chk("upwrap_m2_value", int'(v2), 0);
        chk("upwrap_m2_flag", int'(f2), 1);

        // Down wrap from 0
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("dnwrap_value", int'(v0), 9);
        chk("dnwrap_flag", int'(f0), 1);
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("dn_next_value", int'(v0), 8);
        chk("dn_next_flag", int'(f0), 0);

        // Load overrides count, clamps above MODULO-1
        cyc(1'b1, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
        chk("load7_value", int'(v0), 7);
        chk("load7_flag", int'(f0), 0);
        cyc(1'b1, 1'b1, 8'd200, 1'b0, 1'b1, 1'b0);
        chk("load200_m10", int'(v0), 9);
        chk("load200_m256", int'(v1), 200);
        chk("load200_m2", int'(v2), 1);

        // Hold and direction changes
        cyc(1'b1, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("hold_value", int'(v0), 5);
        chk("hold_flag", int'(f0), 0);
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("dir_up", int'(v0), 6);
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("dir_dn", int'(v0), 5);
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("dir_up2", int'(v0), 6);

`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
        cyc(1'b1, 1'b1, 8'd9, 1'b0, 1'b1, 1'b1);
        chk("sticky_cleared", int'(s0), 0);
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("sticky_set", int'(s0), 1);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("sticky_holds", int'(s0), 1);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        chk("sticky_clr", int'(s0), 0);
        cyc(1'b1, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
        chk("sticky_set_wins", int'(s0), 1);
`endif

        // Randomised traffic, scoreboard checks every cycle
        for (int k = 0; k < 400; k++) begin
            logic rn, ld, ce, ud, clr;
            logic [7:0] lv;
            rn  = ($urandom_range(0, 49) != 0);
            ld  = ($urandom_range(0, 11) == 0);
            ce  = ($urandom_range(0, 9) < 7);
            ud  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            lv  = 8'($urandom);
            cyc(rn, ld, lv, ce, ud, clr);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
